// File: rtl/lcv_mul_acc_pipe.sv
// lcv_mul_acc_pipe: two-stage signed multiply-accumulate with valid/ready on
// both sides, a persistent accumulator, per-beat modes, end-of-group clearing
// and optional saturation.
module lcv_mul_acc_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 40,
  parameter bit SAT       = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_a,
  input  logic signed [IN_WIDTH-1:0]  in_b,
  input  logic signed [ACC_WIDTH-1:0] in_c,
  input  logic [1:0]                  in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_ovf,
  output logic                        out_last
);
  localparam int PW = 2 * IN_WIDTH;   // full product width
  localparam int XW = ACC_WIDTH + 2;  // headroom for the R-stage add/sub

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_MUL_ADD = 2'd0,
    MODE_ACC     = 2'd1,
    MODE_LOAD    = 2'd2,
    MODE_ACC_SUB = 2'd3
  } mode_e;

  // The accumulator must hold any single product plus a sign bit.
  if (ACC_WIDTH < 2 * IN_WIDTH + 1) begin : g_width_check
    $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= 2*IN_WIDTH+1");
  end

  // P stage
  logic                        p_valid_q;
  logic signed [PW-1:0]        p_prod_q;
  logic signed [PW-1:0]        p_prod_d;
  logic signed [ACC_WIDTH-1:0] p_c_q;
  mode_e                       p_mode_q;
  logic                        p_last_q;

  // R stage
  logic                        out_valid_q;
  logic signed [ACC_WIDTH-1:0] out_data_q;
  logic                        out_ovf_q;
  logic                        out_last_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] res_d;
  logic                        ovf_d;
  logic signed [XW-1:0]        r_x;

  logic advance;

  // Both stages shift together whenever the output slot is free or draining.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Bare product so synthesis can map it onto a DSP multiplier.
  assign p_prod_d = PW'(in_a) * PW'(in_b);

  // P-stage register: captures the product and the beat's side information.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data registers are reset too, so outputs and P-stage contents
    // read as 0 during and straight after reset rather than as stale values.
    if (rst) begin
      p_valid_q <= 1'b0;
      p_prod_q  <= '0;
      p_c_q     <= '0;
      p_mode_q  <= MODE_MUL_ADD;
      p_last_q  <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      p_valid_q <= in_valid;
      if (in_valid) begin
        p_prod_q <= p_prod_d;
        p_c_q    <= in_c;
        p_mode_q <= mode_e'(in_mode);
        p_last_q <= in_last;
      end
    end
  end

  // R-stage arithmetic: mode select, overflow detect, clamp or wrap, acc update.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if structure can leave a latch behind.
    r_x   = '0;
    res_d = '0;
    ovf_d = 1'b0;
    acc_d = acc_q;

    unique case (p_mode_q)
      MODE_MUL_ADD: r_x = XW'(p_prod_q) + XW'(p_c_q);
      MODE_ACC:     r_x = XW'(acc_q) + XW'(p_prod_q);
      MODE_LOAD:    r_x = XW'(p_c_q) + XW'(p_prod_q);
      MODE_ACC_SUB: r_x = XW'(acc_q) - XW'(p_prod_q);
    endcase

    // In range only if the bits above the ACC_WIDTH sign bit all match it.
    ovf_d = (r_x[XW-1:ACC_WIDTH-1] != {(XW-ACC_WIDTH+1){r_x[XW-1]}});
    res_d = r_x[ACC_WIDTH-1:0];
    if (SAT && ovf_d) begin
      res_d = r_x[XW-1] ? ACC_MIN : ACC_MAX;
    end

    if (p_valid_q) begin
      if (p_last_q) begin
        acc_d = '0;
      end else if (p_mode_q != MODE_MUL_ADD) begin
        acc_d = res_d;
      end
    end
  end

  // R-stage register: output slot and accumulator, updated only for real beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
      acc_q       <= '0;
    end else if (advance) begin
      out_valid_q <= p_valid_q;
      if (p_valid_q) begin
        out_data_q <= res_d;
        out_ovf_q  <= ovf_d;
        out_last_q <= p_last_q;
        acc_q      <= acc_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// tb_lcv_mul_acc_pipe: directed scenarios plus a randomized stream checked
// against an arithmetic reference model of the multiply-accumulate unit.
module tb_lcv_mul_acc_pipe;
  localparam int IW = 16;
  localparam int AW = 40;
  localparam int SW = 33;

  localparam logic [1:0] M_MUL_ADD = 2'd0;
  localparam logic [1:0] M_ACC     = 2'd1;
  localparam logic [1:0] M_LOAD    = 2'd2;
  localparam logic [1:0] M_ACC_SUB = 2'd3;

  typedef struct {
    bit                   v;
    logic [1:0]           m;
    int                   a;
    int                   b;
    logic signed [AW-1:0] c;
    bit                   l;
  } beat_t;

  typedef struct packed {
    logic                 ovf;
    logic                 last;
    logic signed [AW-1:0] d;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance, default parameters
  logic                 in_valid, in_ready, in_last;
  logic signed [IW-1:0] in_a, in_b;
  logic signed [AW-1:0] in_c;
  logic [1:0]           in_mode;
  logic                 out_valid, out_ready, out_ovf, out_last;
  logic signed [AW-1:0] out_data;

  // Two narrow instances sharing one input set: saturating and wrapping
  logic                 s_valid, s_last;
  logic signed [IW-1:0] s_a, s_b;
  logic signed [SW-1:0] s_c;
  logic [1:0]           s_mode;
  logic                 sat_ready, sat_valid, sat_ovf, sat_last;
  logic signed [SW-1:0] sat_data;
  logic                 wrp_ready, wrp_valid, wrp_ovf, wrp_last;
  logic signed [SW-1:0] wrp_data;

  lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_last(out_last)
  );

  lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(SW), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(sat_ready),
    .in_a(s_a), .in_b(s_b), .in_c(s_c), .in_mode(s_mode), .in_last(s_last),
    .out_valid(sat_valid), .out_ready(1'b1),
    .out_data(sat_data), .out_ovf(sat_ovf), .out_last(sat_last)
  );

  lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(SW), .SAT(1'b0)) dut_wrp (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(wrp_ready),
    .in_a(s_a), .in_b(s_b), .in_c(s_c), .in_mode(s_mode), .in_last(s_last),
    .out_valid(wrp_valid), .out_ready(1'b1),
    .out_data(wrp_data), .out_ovf(wrp_ovf), .out_last(wrp_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Stream driver state
  beat_t                beats[$];
  bit                   rdy_pat[$];
  res_t                 got[$];
  logic                 ir_log[$];
  logic                 v_log[$];
  logic signed [AW-1:0] d_log[$];

  function automatic beat_t mk(input bit v, input logic [1:0] m, input int a,
                               input int b, input longint c, input bit l);
    beat_t r;
    r.v = v; r.m = m; r.a = a; r.b = b; r.c = AW'(c); r.l = l;
    return r;
  endfunction

  // Reference model: exact integer arithmetic, then range check and clamp/wrap.
  function automatic res_t model_beat(input beat_t b, input int aw, input bit sat,
                                      inout longint acc);
    longint prod, c, r, mx, mn, w;
    res_t   o;
    prod = longint'(b.a) * longint'(b.b);
    c    = longint'(b.c);
    case (b.m)
      M_MUL_ADD: r = prod + c;
      M_ACC:     r = acc + prod;
      M_LOAD:    r = c + prod;
      default:   r = acc - prod;
    endcase
    mx = (64'sd1 <<< (aw - 1)) - 1;
    mn = -mx - 1;
    o.ovf = (r > mx) || (r < mn);
    if (!o.ovf)      w = r;
    else if (sat)    w = (r > mx) ? mx : mn;
    else             w = (r <<< (64 - aw)) >>> (64 - aw);
    o.last = b.l;
    o.d    = AW'(w);
    if (b.l)               acc = 0;
    else if (b.m != M_MUL_ADD) acc = w;
    return o;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_mode = M_MUL_ADD; in_last = 1'b0;
  endtask

  task automatic drive(input beat_t b);
    in_valid = b.v; in_mode = b.m; in_a = IW'(b.a); in_b = IW'(b.b);
    in_c = b.c; in_last = b.l;
  endtask

  // Runs the beat queue through the main instance with a per-cycle out_ready
  // pattern; logs the handshake each cycle and captures consumed results.
  task automatic run_stream(input int max_cycles);
    int idx = 0;
    bit bubble;
    res_t r;
    got.delete(); ir_log.delete(); v_log.delete(); d_log.delete();
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      out_ready = (cyc < rdy_pat.size()) ? rdy_pat[cyc] : 1'b1;
      bubble = 1'b0;
      if (idx < beats.size()) begin
        drive(beats[idx]);
        bubble = !beats[idx].v;
      end else begin
        idle_inputs();
      end
      #1;
      ir_log.push_back(in_ready);
      v_log.push_back(out_valid);
      d_log.push_back(out_data);
      if (out_valid && out_ready) begin
        r.ovf = out_ovf; r.last = out_last; r.d = out_data;
        got.push_back(r);
      end
      if ((in_valid && in_ready) || bubble) idx++;
      @(negedge clk);
    end
    idle_inputs();
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); out_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_c = '0; s_mode = M_MUL_ADD; s_last = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_ovf, out_last, out_data, in_ready} !== {3'b000, {AW{1'b0}}, 1'b1})
      $display("FAIL reset_state: valid=%0b ovf=%0b last=%0b data=%0d in_ready=%0b, want 0/0/0/0 ready=1",
               out_valid, out_ovf, out_last, out_data, in_ready);
    else n_pass++;

    // Put a result in R and stall it so outputs are non-zero before reset.
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    drive(mk(1, M_MUL_ADD, 5, 5, 0, 0));
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, in_ready} !== {1'b1, 40'sd25, 1'b0})
      $display("FAIL pre_reset_stall: valid=%0b data=%0d in_ready=%0b, want 1/25/0",
               out_valid, out_data, in_ready);
    else n_pass++;

    // Mid-cycle reset, no clock edge in between.
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_ovf, out_last, out_data, in_ready} !== {3'b000, {AW{1'b0}}, 1'b1})
      $display("FAIL async_reset: valid=%0b ovf=%0b last=%0b data=%0d in_ready=%0b, want 0/0/0/0 ready=1",
               out_valid, out_ovf, out_last, out_data, in_ready);
    else n_pass++;

    @(negedge clk);
    rst = 1'b0;
    beats.delete(); rdy_pat.delete();
    beats.push_back(mk(1, M_MUL_ADD, 1, 1, 0, 0));
    run_stream(5);
    n_checks++;
    if (got.size() != 1 || got[0] !== res_t'{1'b0, 1'b0, 40'sd1})
      $display("FAIL reset_first_beat: count=%0d data=%0d, want count=1 data=1",
               got.size(), (got.size() > 0) ? got[0].d : 40'sd0);
    else n_pass++;
  endtask

  task automatic test_mul_add();
    res_t exp[2];
    exp[0] = '{ovf: 1'b0, last: 1'b0, d: 40'sd79};
    exp[1] = '{ovf: 1'b0, last: 1'b0, d: 40'sd1};
    beats.delete(); rdy_pat.delete();
    beats.push_back(mk(1, M_MUL_ADD, -3, 7, 100, 0));
    beats.push_back(mk(1, M_ACC, 1, 1, 0, 0));
    run_stream(6);
    n_checks++;
    if (v_log[1] !== 1'b0 || v_log[2] !== 1'b1 || d_log[2] !== 40'sd79)
      $display("FAIL mul_add_latency: valid@1=%0b valid@2=%0b data@2=%0d, want 0/1/79",
               v_log[1], v_log[2], d_log[2]);
    else n_pass++;
    n_checks++;
    if (got.size() != 2) $display("FAIL mul_add_count: got %0d results, want 2", got.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i])
        $display("FAIL mul_add_result[%0d]: ovf=%0b last=%0b data=%0d, want ovf=%0b last=%0b data=%0d",
                 i, got[i].ovf, got[i].last, got[i].d, exp[i].ovf, exp[i].last, exp[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    res_t exp[4];
    exp[0] = '{ovf: 1'b0, last: 1'b0, d: 40'sd16};
    exp[1] = '{ovf: 1'b0, last: 1'b0, d: 40'sd36};
    exp[2] = '{ovf: 1'b0, last: 1'b1, d: 40'sd30};
    exp[3] = '{ovf: 1'b0, last: 1'b0, d: 40'sd1};
    beats.delete(); rdy_pat.delete();
    beats.push_back(mk(1, M_LOAD,    2, 3, 10, 0));
    beats.push_back(mk(1, M_ACC,     4, 5, 0,  0));
    beats.push_back(mk(1, M_ACC_SUB, 1, 6, 0,  1));
    beats.push_back(mk(1, M_ACC,     1, 1, 0,  0));
    run_stream(8);
    n_checks++;
    if ({v_log[2], v_log[3], v_log[4], v_log[5]} !== 4'b1111)
      $display("FAIL dot_no_bubble: valid@2..5=%0b%0b%0b%0b, want 1111",
               v_log[2], v_log[3], v_log[4], v_log[5]);
    else n_pass++;
    n_checks++;
    if (got.size() != 4) $display("FAIL dot_count: got %0d results, want 4", got.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i])
        $display("FAIL dot_result[%0d]: ovf=%0b last=%0b data=%0d, want ovf=%0b last=%0b data=%0d",
                 i, got[i].ovf, got[i].last, got[i].d, exp[i].ovf, exp[i].last, exp[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    beats.delete(); rdy_pat.delete();
    beats.push_back(mk(1, M_LOAD, 1, 1, 0, 0));
    for (int i = 0; i < 5; i++) beats.push_back(mk(1, M_ACC, 1, 1, 0, 0));
    rdy_pat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    run_stream(13);
    // Result 2 sits in R during the three stalled cycles.
    for (int c = 3; c <= 5; c++) begin
      n_checks++;
      if ({ir_log[c], v_log[c], d_log[c]} !== {1'b0, 1'b1, 40'sd2})
        $display("FAIL backpressure_stall@%0d: in_ready=%0b valid=%0b data=%0d, want 0/1/2",
                 c, ir_log[c], v_log[c], d_log[c]);
      else n_pass++;
    end
    n_checks++;
    if (got.size() != 6) $display("FAIL backpressure_count: got %0d results, want 6", got.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== res_t'{1'b0, 1'b0, AW'(i + 1)})
        $display("FAIL backpressure_result[%0d]: data=%0d ovf=%0b last=%0b, want data=%0d ovf=0 last=0",
                 i, got[i].d, got[i].ovf, got[i].last, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    // LOAD 1*1 + (2^32-1), then (-32768)^2 with c=0, then ACC 1*1.
    s_valid = 1'b1; s_mode = M_LOAD; s_a = 16'sd1; s_b = 16'sd1;
    s_c = 33'sh0_FFFF_FFFF; s_last = 1'b0;
    @(negedge clk);
    s_mode = M_MUL_ADD; s_a = -16'sd32768; s_b = -16'sd32768; s_c = '0;
    @(negedge clk);
    n_checks++;
    if ({sat_valid, sat_ovf, sat_data} !== {1'b1, 1'b1, 33'sh0_FFFF_FFFF})
      $display("FAIL sat_clamp_hi: valid=%0b ovf=%0b data=%0d, want 1/1/4294967295",
               sat_valid, sat_ovf, sat_data);
    else n_pass++;
    n_checks++;
    if ({wrp_valid, wrp_ovf, wrp_data} !== {1'b1, 1'b1, 33'sh1_0000_0000})
      $display("FAIL wrap_hi: valid=%0b ovf=%0b data=%0d, want 1/1/-4294967296",
               wrp_valid, wrp_ovf, wrp_data);
    else n_pass++;
    s_mode = M_ACC; s_a = 16'sd1; s_b = 16'sd1;
    @(negedge clk);
    n_checks++;
    if ({sat_ovf, sat_data, wrp_ovf, wrp_data} !== {1'b0, 33'sh0_4000_0000, 1'b0, 33'sh0_4000_0000})
      $display("FAIL max_product: sat ovf=%0b data=%0d wrap ovf=%0b data=%0d, want 0/1073741824 both",
               sat_ovf, sat_data, wrp_ovf, wrp_data);
    else n_pass++;
    s_valid = 1'b0;
    @(negedge clk);
    // The accumulator holds the clamped / wrapped value from the LOAD.
    n_checks++;
    if ({sat_valid, sat_ovf, sat_data} !== {1'b1, 1'b1, 33'sh0_FFFF_FFFF})
      $display("FAIL sat_acc_clamped: valid=%0b ovf=%0b data=%0d, want 1/1/4294967295",
               sat_valid, sat_ovf, sat_data);
    else n_pass++;
    n_checks++;
    if ({wrp_valid, wrp_ovf, wrp_data} !== {1'b1, 1'b0, 33'sh1_0000_0001})
      $display("FAIL wrap_acc_wrapped: valid=%0b ovf=%0b data=%0d, want 1/0/-4294967295",
               wrp_valid, wrp_ovf, wrp_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b1;
    drive(mk(1, M_LOAD, 3, 3, 0, 0));
    @(negedge clk);
    drive(mk(1, M_ACC, 1, 1, 0, 0));
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 40'sd9})
      $display("FAIL midstream_pre: valid=%0b data=%0d, want 1/9", out_valid, out_data);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_data} !== {1'b0, 40'sd0})
      $display("FAIL midstream_reset: valid=%0b data=%0d, want 0/0", out_valid, out_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    beats.delete(); rdy_pat.delete();
    beats.push_back(mk(0, M_MUL_ADD, 0, 0, 0, 0));
    beats.push_back(mk(0, M_MUL_ADD, 0, 0, 0, 0));
    beats.push_back(mk(1, M_ACC, 2, 2, 0, 0));
    run_stream(7);
    n_checks++;
    if (got.size() != 1 || got[0] !== res_t'{1'b0, 1'b0, 40'sd4})
      $display("FAIL midstream_after: count=%0d first=%0d, want count=1 data=4",
               got.size(), (got.size() > 0) ? got[0].d : 40'sd0);
    else n_pass++;
  endtask

  task automatic test_random();
    res_t   exp[$];
    longint m_acc = 0;
    logic signed [IW-1:0] ta, tb;
    beat_t  b;
    int     sel;
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    beats.delete(); rdy_pat.delete();
    for (int i = 0; i < 250; i++) begin
      ta = IW'($urandom); tb = IW'($urandom);
      sel = $urandom_range(0, 3);
      b.v = ($urandom_range(0, 7) != 0);
      b.m = 2'($urandom_range(0, 3));
      b.a = int'(ta);
      b.b = int'(tb);
      case (sel)
        0:       b.c = AW'({$urandom, $urandom});
        1:       b.c = 40'sh7F_FFFF_FFFF - AW'($urandom_range(0, 1 << 30));
        2:       b.c = 40'sh80_0000_0000 + AW'($urandom_range(0, 1 << 30));
        default: b.c = AW'($signed(20'($urandom)));
      endcase
      b.l = ($urandom_range(0, 5) == 0);
      beats.push_back(b);
      if (b.v) exp.push_back(model_beat(b, AW, 1'b1, m_acc));
    end
    for (int i = 0; i < 600; i++) rdy_pat.push_back($urandom_range(0, 3) != 0);
    run_stream(900);
    n_checks++;
    if (got.size() != exp.size())
      $display("FAIL random_count: got %0d results, want %0d", got.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i])
        $display("FAIL random_result[%0d]: ovf=%0b last=%0b data=%0d, want ovf=%0b last=%0b data=%0d",
                 i, got[i].ovf, got[i].last, got[i].d, exp[i].ovf, exp[i].last, exp[i].d);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_add();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
